// File: rtl/vertex_ram_ctrl_pkg.sv
`default_nettype none
// ==== vertex_ram_ctrl_pkg : shared vertex type, FSM states and constants ====
// ==== rev 1.0 ====
package vertex_ram_ctrl_pkg;

  localparam int CL_W         = 512;
  localparam int VERTS_PER_CL = 8;
  localparam int CL_SHIFT     = $clog2(VERTS_PER_CL);
  localparam int VERT_W       = CL_W / VERTS_PER_CL;
  localparam int RAM_RD_LAT   = 2;
  localparam int RSP_DEPTH    = 4;

  typedef logic [VERT_W-1:0] vertex_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vertex_ram_ctrl_if.sv
`default_nettype none
// ==== vertex_ram_ctrl_if : load, cacheline, read-request/response and RAM bus ====
// ==== rev 1.0 ====
interface vertex_ram_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 6
);
  import vertex_ram_ctrl_pkg::*;

  logic                   load_start;
  logic [ADDR_W-CL_SHIFT:0] load_num_cl;
  logic                   cl_valid;
  logic [CL_W-1:0]        cl_data;
  logic                   cl_ready;
  logic                   rd_req_valid;
  logic [ADDR_W-1:0]      rd_req_addr;
  logic [TAG_W-1:0]       rd_req_tag;
  logic                   rd_req_ready;
  logic                   rd_rsp_valid;
  vertex_t                rd_rsp_vertex;
  logic [TAG_W-1:0]       rd_rsp_tag;
  logic                   rd_rsp_ready;
  logic [CL_W-1:0]        ram_cl;
  logic [ADDR_W-1:0]      ram_w_addr;
  logic [ADDR_W-1:0]      ram_r_addr;
  logic                   ram_we;
  vertex_t                ram_vertex;
  logic                   loaded;
  logic                   busy;

  modport slave (
    input  load_start, load_num_cl, cl_valid, cl_data, rd_req_valid, rd_req_addr,
           rd_req_tag, rd_rsp_ready, ram_vertex,
    output cl_ready, rd_req_ready, rd_rsp_valid, rd_rsp_vertex, rd_rsp_tag,
           ram_cl, ram_w_addr, ram_r_addr, ram_we, loaded, busy
  );

  modport master (
    output load_start, load_num_cl, cl_valid, cl_data, rd_req_valid, rd_req_addr,
           rd_req_tag, rd_rsp_ready, ram_vertex,
    input  cl_ready, rd_req_ready, rd_rsp_valid, rd_rsp_vertex, rd_rsp_tag,
           ram_cl, ram_w_addr, ram_r_addr, ram_we, loaded, busy
  );

endinterface
`default_nettype wire

// File: rtl/vertex_ram_ctrl_rsp_fifo.sv
`default_nettype none
// ==== vertex_ram_ctrl_rsp_fifo : small synchronous FIFO holding read responses ====
// ==== rev 1.0 ====
module vertex_ram_ctrl_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is accepted only when an entry leaves the same cycle.
  assign do_push  = push && ((count != FULL_CNT) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/vertex_ram_ctrl.sv
`default_nettype none
// ==== vertex_ram_ctrl : partition loader and tagged read server for the vertex RAM ====
// ==== rev 1.0 ====
module vertex_ram_ctrl
  import vertex_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  vertex_ram_ctrl_if.slave bus
);
  localparam int CNT_W   = ADDR_W - CL_SHIFT + 1;
  localparam int ENT_W   = TAG_W + $bits(vertex_t);
  localparam int FCNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam int INF_W   = $clog2(RAM_RD_LAT + 1);
  localparam logic [FCNT_W-1:0] RSP_CREDITS = RSP_DEPTH[FCNT_W-1:0];

  state_t              state;
  logic [CNT_W-1:0]    cl_cnt;
  logic [CNT_W-1:0]    cl_cnt_nxt;
  logic [CNT_W-1:0]    num_cl;
  logic                loaded_r;
  logic [INF_W-1:0]    inflight;
  logic [RAM_RD_LAT-1:0] vld_pipe;
  logic [TAG_W-1:0]    tag_pipe [RAM_RD_LAT];
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty;
  logic [ENT_W-1:0]    fifo_rd_data;
  logic                cl_acc;
  logic                req_hs;
  logic                capture;
  logic                rsp_pop;

  assign cl_acc     = bus.cl_valid && bus.cl_ready;
  assign req_hs     = bus.rd_req_valid && bus.rd_req_ready;
  assign capture    = vld_pipe[RAM_RD_LAT-1];
  assign rsp_pop    = bus.rd_rsp_valid && bus.rd_rsp_ready;
  assign cl_cnt_nxt = cl_cnt + CNT_W'(1);

  assign bus.cl_ready   = (state == ST_LOAD);
  assign bus.ram_we     = cl_acc;
  assign bus.ram_cl     = bus.cl_data;
  assign bus.ram_w_addr = {cl_cnt[CNT_W-2:0], {CL_SHIFT{1'b0}}};
  assign bus.ram_r_addr = bus.rd_req_addr;
  assign bus.loaded     = loaded_r;
  assign bus.busy       = (state != ST_IDLE);
  // Every accepted request owns a FIFO slot until popped, so the FIFO never overflows.
  assign bus.rd_req_ready = (state == ST_SERVE) &&
      (({{(FCNT_W-INF_W){1'b0}}, inflight} + fifo_count) < RSP_CREDITS);
  assign bus.rd_rsp_valid = !fifo_empty;
  assign {bus.rd_rsp_tag, bus.rd_rsp_vertex} = fifo_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cl_cnt   <= '0;
      num_cl   <= '0;
      loaded_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.load_start) begin
          state    <= ST_LOAD;
          num_cl   <= bus.load_num_cl;
          cl_cnt   <= '0;
          loaded_r <= 1'b0;
        end
        ST_LOAD: if (num_cl == '0) begin
          state    <= ST_SERVE;
          loaded_r <= 1'b1;
        end else if (cl_acc) begin
          cl_cnt <= cl_cnt_nxt;
          if (cl_cnt_nxt == num_cl) begin
            state    <= ST_SERVE;
            loaded_r <= 1'b1;
          end
        end
        ST_SERVE: if (bus.load_start) begin
          state  <= ST_DRAIN;
          num_cl <= bus.load_num_cl;
        end
        ST_DRAIN: if (inflight == '0) begin
          state    <= ST_LOAD;
          cl_cnt   <= '0;
          loaded_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Valid bits model the fixed RAM latency; reset drops anything still in the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RAM_RD_LAT-2:0], req_hs};
      case ({req_hs, capture})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    tag_pipe[0] <= bus.rd_req_tag;
    for (int i = 1; i < RAM_RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
  end

  vertex_ram_ctrl_rsp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data ({tag_pipe[RAM_RD_LAT-1], bus.ram_vertex}),
    .pop       (rsp_pop),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_vertex_ram_ctrl.sv
`default_nettype none
// ==== tb_vertex_ram_ctrl : directed self-checking bench with a 2-cycle vertex RAM model ====
// ==== rev 1.0 ====
module tb_vertex_ram_ctrl;
  import vertex_ram_ctrl_pkg::*;

  localparam int ADDR_W = 8;
  localparam int TAG_W  = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   acc;

  vertex_ram_ctrl_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bif ();

  vertex_ram_ctrl #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Vertex RAM beside the controller: address register then data register.
  vertex_t           mem [2**ADDR_W];
  logic [ADDR_W-1:0] ra1;
  vertex_t           rd_q;
  always @(posedge clk) begin
    if (bif.ram_we)
      for (int j = 0; j < VERTS_PER_CL; j++)
        mem[int'(bif.ram_w_addr) + j] <= bif.ram_cl[j*VERT_W +: VERT_W];
    ra1  <= bif.ram_r_addr;
    rd_q <= mem[ra1];
  end
  assign bif.ram_vertex = rd_q;

  function automatic vertex_t vx(input logic [15:0] id, input int a);
    return {id, 16'h0000, a[31:0]};
  endfunction

  function automatic logic [CL_W-1:0] mk_cl(input logic [15:0] id, input int k);
    logic [CL_W-1:0] r;
    r = '0;
    for (int j = 0; j < VERTS_PER_CL; j++) r[j*VERT_W +: VERT_W] = vx(id, k*VERTS_PER_CL + j);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_loaded"},       64'(bif.loaded),       64'd0);
    chk({tag, "_busy"},         64'(bif.busy),         64'd0);
    chk({tag, "_cl_ready"},     64'(bif.cl_ready),     64'd0);
    chk({tag, "_rd_req_ready"}, 64'(bif.rd_req_ready), 64'd0);
    chk({tag, "_rd_rsp_valid"}, 64'(bif.rd_rsp_valid), 64'd0);
    chk({tag, "_ram_we"},       64'(bif.ram_we),       64'd0);
  endtask

  initial begin
    bif.load_start   = 1'b0;
    bif.load_num_cl  = '0;
    bif.cl_valid     = 1'b0;
    bif.cl_data      = '0;
    bif.rd_req_valid = 1'b0;
    bif.rd_req_addr  = '0;
    bif.rd_req_tag   = '0;
    bif.rd_rsp_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    #1;
    check_reset("rst");
    reset = 1'b0;

    // Three-cacheline load with one idle cycle between lines
    bif.load_start = 1'b1; bif.load_num_cl = 6'd3;
    step();
    bif.load_start = 1'b0; bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00A0, 0);
    #1;
    chk("load_cl_ready", 64'(bif.cl_ready), 64'd1);
    chk("load_busy",     64'(bif.busy),     64'd1);
    chk("load_we_a",     64'(bif.ram_we),   64'd1);
    chk("load_waddr_a",  64'(bif.ram_w_addr), 64'h00);
    step();
    bif.cl_valid = 1'b0;
    #1;
    chk("load_gap_we", 64'(bif.ram_we), 64'd0);
    step();
    bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00A0, 1);
    #1;
    chk("load_waddr_b", 64'(bif.ram_w_addr), 64'h08);
    step();
    bif.cl_valid = 1'b0;
    step();
    bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00A0, 2);
    #1;
    chk("load_waddr_c",     64'(bif.ram_w_addr), 64'h10);
    chk("load_not_yet",     64'(bif.loaded),     64'd0);
    step();
    bif.cl_valid = 1'b0;
    #1;
    chk("load_loaded",      64'(bif.loaded),       64'd1);
    chk("load_serve_clrdy", 64'(bif.cl_ready),     64'd0);
    chk("load_serve_reqrdy",64'(bif.rd_req_ready), 64'd1);

    // Zero-length load: one DRAIN cycle, one LOAD cycle, then SERVE
    bif.load_start = 1'b1; bif.load_num_cl = 6'd0;
    step();
    bif.load_start = 1'b0;
    #1;
    chk("zl_drain_clrdy", 64'(bif.cl_ready), 64'd0);
    step();
    #1;
    chk("zl_load_clrdy", 64'(bif.cl_ready), 64'd1);
    chk("zl_load_loaded",64'(bif.loaded),   64'd0);
    chk("zl_no_we",      64'(bif.ram_we),   64'd0);
    step();
    #1;
    chk("zl_serve_clrdy", 64'(bif.cl_ready), 64'd0);
    chk("zl_serve_loaded",64'(bif.loaded),   64'd1);

    // Full 32-line load
    bif.load_start = 1'b1; bif.load_num_cl = 6'd32;
    step();
    bif.load_start = 1'b0;
    step();
    #1;
    chk("full_enter_load", 64'(bif.cl_ready), 64'd1);
    for (int k = 0; k < 32; k++) begin
      bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00F0, k);
      #1;
      if (k == 31) chk("full_last_waddr", 64'(bif.ram_w_addr), 64'hF8);
      step();
    end
    bif.cl_valid = 1'b0;
    #1;
    chk("full_loaded", 64'(bif.loaded), 64'd1);

    // Streaming reads
    bif.rd_rsp_ready = 1'b1;
    bif.rd_req_valid = 1'b1; bif.rd_req_addr = 8'd5; bif.rd_req_tag = 6'd1;
    #1;
    chk("st_req_ready", 64'(bif.rd_req_ready), 64'd1);
    chk("st_r_addr",    64'(bif.ram_r_addr),   64'd5);
    step();
    bif.rd_req_addr = 8'd9; bif.rd_req_tag = 6'd2;
    step();
    bif.rd_req_addr = 8'd200; bif.rd_req_tag = 6'd3;
    #1;
    chk("st_no_early_rsp", 64'(bif.rd_rsp_valid), 64'd0);
    step();
    bif.rd_req_valid = 1'b0;
    #1;
    chk("st_rsp1_valid", 64'(bif.rd_rsp_valid), 64'd1);
    chk("st_rsp1_tag",   64'(bif.rd_rsp_tag),   64'd1);
    chk("st_rsp1_vert",  bif.rd_rsp_vertex,     64'h00F0_0000_0000_0005);
    step();
    chk("st_rsp2_tag",   64'(bif.rd_rsp_tag),   64'd2);
    chk("st_rsp2_vert",  bif.rd_rsp_vertex,     64'h00F0_0000_0000_0009);
    step();
    chk("st_rsp3_tag",   64'(bif.rd_rsp_tag),   64'd3);
    chk("st_rsp3_vert",  bif.rd_rsp_vertex,     64'h00F0_0000_0000_00C8);
    step();
    chk("st_idle_rsp",   64'(bif.rd_rsp_valid), 64'd0);

    // Backpressure: six requests offered against a stalled response port
    bif.rd_rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bif.rd_req_valid = 1'b1;
      bif.rd_req_addr  = 8'(16 + acc);
      bif.rd_req_tag   = 6'(10 + acc);
      #1;
      if (bif.rd_req_ready) acc++;
      step();
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    #1;
    chk("bp_req_blocked", 64'(bif.rd_req_ready), 64'd0);
    chk("bp_rsp_held",    64'(bif.rd_rsp_valid), 64'd1);
    bif.rd_req_valid = 1'b0;
    bif.rd_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_drain_valid", 64'(bif.rd_rsp_valid), 64'd1);
      chk("bp_drain_tag",   64'(bif.rd_rsp_tag),   64'(10 + i));
      chk("bp_drain_vert",  bif.rd_rsp_vertex,     vx(16'h00F0, 16 + i));
      step();
    end
    #1;
    chk("bp_empty",   64'(bif.rd_rsp_valid), 64'd0);
    chk("bp_resumed", 64'(bif.rd_req_ready), 64'd1);
    bif.rd_req_valid = 1'b1; bif.rd_req_addr = 8'd20; bif.rd_req_tag = 6'd14;
    step();
    bif.rd_req_valid = 1'b0;
    step();
    step();
    #1;
    chk("bp_late_tag",  64'(bif.rd_rsp_tag), 64'd14);
    chk("bp_late_vert", bif.rd_rsp_vertex,   vx(16'h00F0, 20));
    step();

    // Reload with two reads in flight
    bif.rd_req_valid = 1'b1; bif.rd_req_addr = 8'd0; bif.rd_req_tag = 6'd20;
    step();
    bif.rd_req_addr = 8'd1; bif.rd_req_tag = 6'd21;
    step();
    bif.rd_req_valid = 1'b0;
    bif.load_start = 1'b1; bif.load_num_cl = 6'd1;
    step();
    bif.load_start = 1'b0;
    #1;
    chk("rl_drain1_clrdy", 64'(bif.cl_ready),   64'd0);
    chk("rl_old1_tag",     64'(bif.rd_rsp_tag), 64'd20);
    chk("rl_old1_vert",    bif.rd_rsp_vertex,   vx(16'h00F0, 0));
    step();
    chk("rl_drain2_clrdy", 64'(bif.cl_ready),   64'd0);
    chk("rl_old2_tag",     64'(bif.rd_rsp_tag), 64'd21);
    chk("rl_old2_vert",    bif.rd_rsp_vertex,   vx(16'h00F0, 1));
    step();
    bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00D0, 0);
    #1;
    chk("rl_load_clrdy", 64'(bif.cl_ready),   64'd1);
    chk("rl_load_we",    64'(bif.ram_we),     64'd1);
    chk("rl_load_waddr", 64'(bif.ram_w_addr), 64'h00);
    chk("rl_load_clear", 64'(bif.loaded),     64'd0);
    step();
    bif.cl_valid = 1'b0;
    #1;
    chk("rl_loaded", 64'(bif.loaded), 64'd1);
    bif.rd_req_valid = 1'b1; bif.rd_req_addr = 8'd0; bif.rd_req_tag = 6'd22;
    step();
    bif.rd_req_valid = 1'b0;
    step();
    step();
    #1;
    chk("rl_new_tag",  64'(bif.rd_rsp_tag), 64'd22);
    chk("rl_new_vert", bif.rd_rsp_vertex,   vx(16'h00D0, 0));
    step();

    // Reset after one of four cachelines
    bif.load_start = 1'b1; bif.load_num_cl = 6'd4;
    step();
    bif.load_start = 1'b0;
    step();
    bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00B0, 0);
    #1;
    chk("ml_first_we", 64'(bif.ram_we), 64'd1);
    step();
    bif.cl_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_reset("ml_rst");
    bif.load_start = 1'b1; bif.load_num_cl = 6'd1;
    step();
    bif.load_start = 1'b0;
    bif.cl_valid = 1'b1; bif.cl_data = mk_cl(16'h00B0, 1);
    #1;
    chk("ml_restart_we",    64'(bif.ram_we),     64'd1);
    chk("ml_restart_waddr", 64'(bif.ram_w_addr), 64'h00);
    step();
    bif.cl_valid = 1'b0;
    #1;
    chk("ml_restart_loaded", 64'(bif.loaded), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vertex_ram_ctrl.md
VERTEX_RAM_CTRL -- requirements
Module: vertex_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: vertex address width; vertex_ram depth is 2**ADDR_W and each cacheline holds 8 vertices.
REQ-002 SHALL have parameter TAG_W, default 6: width of the read-request tag returned with each response.
REQ-003 SHALL have port clk  in  1: single clock; all logic samples on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port load_start  in  1: one-cycle pulse that begins a partition load.
REQ-006 SHALL have port load_num_cl  in  ADDR_W-3+1: number of cachelines to load, sampled on an accepted load_start.
REQ-007 SHALL have ports cl_valid  in  1 / cl_data  in  512 / cl_ready  out  1: cacheline input stream with valid/ready handshake.
REQ-008 SHALL have ports rd_req_valid  in  1 / rd_req_addr  in  ADDR_W / rd_req_tag  in  TAG_W / rd_req_ready  out  1: vertex read requests.
REQ-009 SHALL have ports rd_rsp_valid  out  1 / rd_rsp_vertex  out  vertex_t / rd_rsp_tag  out  TAG_W / rd_rsp_ready  in  1: vertex read responses.
REQ-010 SHALL have ports ram_cl  out  512 / ram_w_addr  out  ADDR_W / ram_r_addr  out  ADDR_W / ram_we  out  1 / ram_vertex  in  vertex_t: connection to the banked vertex RAM.
REQ-011 SHALL have ports loaded  out  1 / busy  out  1: status outputs; loaded means partition resident, busy means state != IDLE.

Function
REQ-012 SHALL implement the states IDLE, LOAD, SERVE and DRAIN.
REQ-013 Transitions SHALL be:
- IDLE, on load_start: to LOAD.
- SERVE, on load_start: to DRAIN.
- DRAIN, when the in-flight count is 0: to LOAD.
- LOAD, once load_num_cl cachelines have been accepted: to SERVE.
- LOAD, when load_num_cl is 0: to SERVE on the next cycle.
REQ-014 SHALL ignore load_start while in LOAD or DRAIN.
REQ-015 SHALL drive cl_ready = (state == LOAD).
REQ-016 On each cl_valid && cl_ready cycle, SHALL drive the following combinationally in that cycle: ram_we=1, ram_cl=cl_data, ram_w_addr={cl_cnt,3'b000}; cl_cnt then increments.
REQ-017 SHALL drive ram_we=0 on every cycle with no accepted cacheline.
REQ-018 SHALL clear loaded on entry to LOAD and set it on entry to SERVE.
REQ-019 SHALL drive rd_req_ready = (state == SERVE) && (inflight + fifo_count < 4).
REQ-020 SHALL drive ram_r_addr = rd_req_addr combinationally.
REQ-021 SHALL treat the vertex RAM read latency as exactly 2 cycles: ram_vertex is captured 2 cycles after the request handshake, together with a tag delayed by 2 cycles.
REQ-022 SHALL hold captured responses in a 4-entry FIFO.
REQ-023 SHALL drive rd_rsp_valid = FIFO not empty; an entry pops on rd_rsp_valid && rd_rsp_ready.
REQ-024 SHALL return responses in request order.
REQ-025 The credit rule of REQ-019 SHALL guarantee no FIFO overflow under any rd_rsp_ready pattern.
REQ-026 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-027 The inflight counter (range 0..2) SHALL increment on a request handshake and decrement on capture; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-028 In DRAIN, SHALL not issue cacheline writes until inflight == 0; FIFO contents are preserved and continue to drain.

Reset
REQ-029 On reset, SHALL force:
- state = IDLE
- cl_cnt = 0, inflight = 0, FIFO emptied
- loaded = 0, busy = 0, cl_ready = 0, rd_req_ready = 0, rd_rsp_valid = 0, ram_we = 0
REQ-030 Reset asserted mid-LOAD or mid-SERVE SHALL abandon the operation; in-flight reads are discarded and no response is emitted for them.
REQ-031 RAM contents SHALL NOT be cleared by reset; loaded=0 marks them invalid.

Structure
REQ-032 vertex_t and the constants VERTS_PER_CL=8 and RAM_RD_LAT=2 SHALL live in the shared graph package/header.
REQ-033 SHALL contain one natural sub-module, rsp_fifo: a 4-entry, TAG_W+$bits(vertex_t)-wide synchronous FIFO.
REQ-034 SHALL instantiate no RAM itself; vertex_ram sits beside it.

Verification
REQ-035 Scenario load: load_start with load_num_cl=3, cachelines A, B, C with a 1-cycle valid gap -> ram_we pulses with ram_w_addr 0x00, 0x08, 0x10; loaded=1 on the cycle after C.
REQ-036 Scenario zero-length load: load_num_cl=0 -> LOAD for exactly one cycle, then SERVE; cl_ready high for one cycle; no ram_we.
REQ-037 Scenario streaming reads: rd_rsp_ready=1, back-to-back requests at addr 5, 9, 200 with tags 1, 2, 3 -> responses 2 cycles after each request, same order and tags, vertex values matching the loaded data.
REQ-038 Scenario backpressure: rd_rsp_ready=0, 6 requests offered -> exactly 4 accepted, rd_req_ready low thereafter; raising rd_rsp_ready drains 4 responses, then acceptance resumes.
REQ-039 Scenario reload: load_start issued with inflight=2 -> DRAIN for 2 cycles, both old-data responses delivered, then LOAD overwrites addr 0.
REQ-040 Scenario reset mid-load: reset after 1 of 4 cachelines -> all outputs at reset values next cycle; a subsequent load restarts at ram_w_addr 0.
